// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequencer and its decoder:
// opcodes, register roles and the sequencer state encoding.
package fib_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_MOV  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_OUT  = 3'b100;

    localparam logic [1:0] REG_A = 2'd0;
    localparam logic [1:0] REG_B = 2'd1;
    localparam logic [1:0] REG_T = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT0 = 3'd1,
        ST_INIT1 = 3'd2,
        ST_LOUT  = 3'd3,
        ST_LMOV1 = 3'd4,
        ST_LADD  = 3'd5,
        ST_LMOV2 = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

endpackage

// File: rtl/fib_instr_sequencer_if.sv
// Control and instruction bus of the Fibonacci sequencer.
// The sequencer side uses the master modport, the control/decoder side the slave modport.
// Optional macro SEQ_STALL_EN adds the stall input.
interface fib_instr_sequencer_if #(
    parameter int CW = 4,
    parameter int DW = 8
);
    logic          start;
    logic [CW-1:0] n_terms;
`ifdef SEQ_STALL_EN
    logic          stall;
`endif
    logic [2:0]    opcode;
    logic [1:0]    op1;
    logic [1:0]    op2;
    logic [DW-1:0] imm;
    logic          instr_valid;
    logic          busy;
    logic          done;
    logic [CW-1:0] term_idx;

    modport master (
        input  start,
        input  n_terms,
`ifdef SEQ_STALL_EN
        input  stall,
`endif
        output opcode,
        output op1,
        output op2,
        output imm,
        output instr_valid,
        output busy,
        output done,
        output term_idx
    );

    modport slave (
        output start,
        output n_terms,
`ifdef SEQ_STALL_EN
        output stall,
`endif
        input  opcode,
        input  op1,
        input  op2,
        input  imm,
        input  instr_valid,
        input  busy,
        input  done,
        input  term_idx
    );

endinterface

// File: rtl/fib_instr_rom.sv
// Fixed program store: maps the sequencer state to the instruction it issues.
module fib_instr_rom
    import fib_pkg::*;
#(
    parameter int DW = 8
) (
    input  state_t        state,
    output logic [2:0]    opcode,
    output logic [1:0]    op1,
    output logic [1:0]    op2,
    output logic [DW-1:0] imm,
    output logic          valid
);

    // Decode each program state into its instruction; idle and done issue a NOP
    always_comb begin
        opcode = OP_NOP;
        op1    = 2'd0;
        op2    = 2'd0;
        imm    = '0;
        valid  = 1'b0;
        case (state)
            ST_INIT0: begin
                opcode = OP_LOAD;
                op1    = REG_A;
                imm    = '0;
                valid  = 1'b1;
            end
            ST_INIT1: begin
                opcode = OP_LOAD;
                op1    = REG_B;
                imm    = DW'(1);
                valid  = 1'b1;
            end
            ST_LOUT: begin
                opcode = OP_OUT;
                op1    = REG_A;
                valid  = 1'b1;
            end
            ST_LMOV1: begin
                opcode = OP_MOV;
                op1    = REG_T;
                op2    = REG_B;
                valid  = 1'b1;
            end
            ST_LADD: begin
                opcode = OP_ADD;
                op1    = REG_B;
                op2    = REG_A;
                valid  = 1'b1;
            end
            ST_LMOV2: begin
                opcode = OP_MOV;
                op1    = REG_A;
                op2    = REG_T;
                valid  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fib_instr_sequencer.sv
// Instruction issuer for the Fibonacci datapath: two LOADs, then an
// OUT/MOV/ADD/MOV loop producing F0..F(N-1), one instruction per clock.
// Optional macro SEQ_STALL_EN: stall input freezes the machine outside IDLE.
module fib_instr_sequencer
    import fib_pkg::*;
#(
    parameter int CW = 4,
    parameter int DW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    fib_instr_sequencer_if.master  bus
);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] count_q;
    logic [CW-1:0] term_idx_q;
    logic          hold;
    logic          rom_valid;
    logic          last_term;

    // The loop ends on the OUT that brings the issued count up to the latched length
    assign last_term = ((term_idx_q + CW'(1)) == count_q);

    // Stall freezes everything except in IDLE, where start must still be seen
    always_comb begin
`ifdef SEQ_STALL_EN
        hold = bus.stall && (state != ST_IDLE);
`else
        hold = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state logic following the fixed program order
    always_comb begin
        next_state = state;
        if (!hold) begin
            case (state)
                ST_IDLE:  if (bus.start) next_state = (bus.n_terms == '0) ? ST_DONE : ST_INIT0;
                ST_INIT0: next_state = ST_INIT1;
                ST_INIT1: next_state = ST_LOUT;
                ST_LOUT:  next_state = last_term ? ST_DONE : ST_LMOV1;
                ST_LMOV1: next_state = ST_LADD;
                ST_LADD:  next_state = ST_LMOV2;
                ST_LMOV2: next_state = ST_LOUT;
                ST_DONE:  next_state = ST_IDLE;
                default:  next_state = ST_IDLE;
            endcase
        end
    end

    // Run length is captured only on an accepted start; term count advances once per OUT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            term_idx_q <= '0;
        end else if (state == ST_IDLE && bus.start) begin
            count_q    <= bus.n_terms;
            term_idx_q <= '0;
        end else if (state == ST_LOUT && !hold) begin
            term_idx_q <= term_idx_q + CW'(1);
        end
    end

    fib_instr_rom #(.DW(DW)) u_rom (
        .state  (state),
        .opcode (bus.opcode),
        .op1    (bus.op1),
        .op2    (bus.op2),
        .imm    (bus.imm),
        .valid  (rom_valid)
    );

    // Handshake outputs derived from the state register; a stalled instruction is marked invalid
    always_comb begin
        bus.instr_valid = rom_valid && !hold;
        bus.busy        = (state != ST_IDLE);
        bus.done        = (state == ST_DONE);
        bus.term_idx    = term_idx_q;
    end

endmodule
